mlp_stream: RTL
===============

# mlp_stream

Streaming, parametrised successor to the time-multiplexed 2-layer MLP. It processes one token (E-element vector) at a time through FC1 (E→H), a selectable activation, and FC2 (H→E), using a single MAC.
- Arithmetic is signed fixed-point with rounding and saturation.
- Weights and biases live in internal RAM, loaded through a write port.
- Tokens enter and leave through valid/ready handshakes, so the block sits inline in the transformer token stream with no flattened L×N buses.

## Interface
- DATA_WIDTH, 16, signed element width (two's complement)
- FRAC_BITS, 8, fractional bits of the Q format for data, weights and biases
- E, 8, input/output embedding dimension
- H, 32, hidden dimension
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(H)+1, accumulator width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- w_we  in  1  weight write strobe
- w_sel  in  2  target: 0=W1, 1=b1, 2=W2, 3=b2
- w_addr  in  $clog2(E*H)  index:
  - W1: e*H+h
  - b1: h
  - W2: h*E+e
  - b2: e
- w_data  in  DATA_WIDTH  value written
- w_err  out  1  one-cycle pulse when a write is rejected
- act_mode  in  2  activation: 0=none, 1=ReLU, 2=leaky (x>>>3), 3=none; sampled at input accept
- in_valid  in  1  token present
- in_ready  out  1  high only in S_IDLE
- in_data  in  DATA_WIDTH*E  token, element e at [e*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH*E  result, same packing as in_data
- busy  out  1  state ≠ S_IDLE

## Operation
- States and transitions:
  - S_IDLE → S_FC1 on in_valid&&in_ready.
  - S_FC1 → S_FC2 after E*H MAC cycles.
  - S_FC2 → S_OUT after H*E MAC cycles.
  - S_OUT → S_IDLE on out_valid&&out_ready.
- Accept: latch in_data into x_reg[E] and act_mode into mode_reg.
- FC1: for h=0..H-1, acc = b1[h]<<FRAC_BITS, then acc += x[e]*W1[e][h] for e=0..E-1 (one MAC per cycle). On the last e, the finalised acc+product is written to hid[h] after:
  - round: add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS;
  - saturate to [-2^(DW-1), 2^(DW-1)-1];
  - activate per mode_reg.
- FC2: same scheme over h with W2/b2, writing y_reg[e], saturated, with no activation.
- Weight writes: accepted only in S_IDLE with w_addr inside the target's range; otherwise ignored and w_err pulses the next cycle. Weight RAM takes effect for the next accepted token.
- Weight RAM, hid and x_reg are not reset. Contents survive rst_n.

## Timing
- Reset values: in_ready=1 (S_IDLE), out_valid=0, out_data=0, busy=0, w_err=0. All counters and the accumulator are 0.
- Token accepted at edge T → out_valid high from cycle T+2*E*H+1.
- No overlap: in_ready stays 0 from acceptance until the output handshake completes. A next token can be accepted at the earliest one cycle after the out handshake.
- out_data is stable while out_valid && !out_ready. out_valid drops the cycle after the handshake.
- Simultaneous w_we and input accept in S_IDLE: the write completes, and the token uses the new value (write precedes the FC1 read by ≥1 cycle).
- rst_n asserted mid-operation: abort to S_IDLE immediately. The partial result is discarded; no out_valid.
- MAC is one registered stage. The product is full 2*DATA_WIDTH; accumulation runs at ACC_WIDTH with no intermediate saturation.

## Structure
- mlp_pkg: state_t enum, act_mode encodings, w_sel encodings, and the function sat_round(acc, FRAC_BITS, DATA_WIDTH).
- Sub-module mlp_mac_unit: multiply-accumulate plus round/saturate/activate output path, reused by both layers.
- W1/W2/b1/b2 are inferred synchronous RAMs in mlp_stream.

## Test plan
Config for all scenarios: E=2, H=4, DATA_WIDTH=16, FRAC_BITS=8.

- Basic path:
  - Stimulus: W1=0x0100, W2=0x0040, biases 0, mode 0, x=[0x0100,0x0200].
  - Required: out=[0x0300,0x0300]; out_valid exactly 17 cycles after accept.
- ReLU:
  - Stimulus: as above with x=[0xFF00,0xFE00], b2=0x0080, mode 1.
  - Required: out=[0x0080,0x0080].
- Leaky:
  - Stimulus: same as ReLU, mode 2.
  - Required: hidden=0xFFA0, out=[0x0020,0x0020].
- Saturation:
  - Stimulus: W1=0x7FFF, x=[0x7FFF,0x7FFF], W2=0x0100, mode 0.
  - Required: out=[0x7FFF,0x7FFF]. Repeat with x negated → [0x8000,0x8000].
- Backpressure / write rejection:
  - Stimulus: hold out_ready=0 for 10 cycles, with a second token waiting, and w_we issued while busy.
  - Required: out_data stable and in_ready=0 throughout; w_err pulses and weights are unchanged; the second token is accepted the cycle after the handshake.
- Reset mid-FC2:
  - Stimulus: assert rst_n low mid-FC2.
  - Required: out_valid=0 and in_ready=1 immediately; a new token (no reload) reproduces the basic-path result.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the streaming MLP.
//   state_t    : controller states
//   act_mode_t : activation selector (sampled with each accepted token)
//   w_sel_t    : weight-port target
//   sat_round  : round-half-up, arithmetic shift and saturate a wide accumulator
package mlp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FC1  = 2'd1,
        S_FC2  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE     = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_LEAKY    = 2'd2,
        ACT_NONE_ALT = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        SEL_W1 = 2'd0,
        SEL_B1 = 2'd1,
        SEL_W2 = 2'd2,
        SEL_B2 = 2'd3
    } w_sel_t;

    localparam int LEAKY_SHIFT = 3;

    // Rounds to nearest (ties up), drops frac_bits, clamps to a signed
    // data_width range. frac_bits must be at least 1.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int frac_bits,
                                                     input int data_width);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        max_v = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (r > max_v) return max_v;
        if (r < min_v) return min_v;
        return r;
    endfunction

endpackage

// File: rtl/mlp_stream_if.sv
// Token stream between mlp_stream and its neighbours.
//   in_valid/in_ready/in_data    : input token, element e at [e*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready/out_data : result token, same packing
// master = the token source/sink around the block, slave = mlp_stream.
interface mlp_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int E          = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH*E-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH*E-1:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/mlp_mac_unit.sv
// Single multiply-accumulate shared by both layers, plus the finalising path.
//   en     : accumulate this cycle
//   first  : first term of a neuron; accumulator restarts from bias<<FRAC_BITS
//   a, b   : operand and weight
//   bias   : neuron bias (used when first)
//   mode   : activation applied to the finalised value
//   result : round/saturate/activate of (accumulator + current product)
module mlp_mac_unit
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 38
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         first,
    input  act_mode_t                    mode,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] result
);
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    acc_base;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [DATA_WIDTH-1:0]   sat_v;

    // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
    always_comb begin
        product  = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        acc_base = first ? (ACC_WIDTH'(bias) <<< FRAC_BITS) : acc;
        sum      = acc_base + ACC_WIDTH'(product);
        sat_v    = DATA_WIDTH'(sat_round(64'(sum), FRAC_BITS, DATA_WIDTH));
        result   = sat_v;
        case (mode)
            ACT_RELU:  if (sat_v[DATA_WIDTH-1]) result = '0;
            ACT_LEAKY: if (sat_v[DATA_WIDTH-1]) result = sat_v >>> LEAKY_SHIFT;
            default:   result = sat_v;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  acc <= '0;
        else if (en) acc <= sum;
    end
endmodule

// File: rtl/mlp_stream.sv
// Streaming 2-layer MLP: FC1 (E->H) + activation, FC2 (H->E), one MAC.
//   clk, rst_n            : clock, asynchronous active-low reset
//   w_we/w_sel/w_addr/w_data : weight RAM write port (W1, b1, W2, b2), idle only
//   w_err                 : one-cycle pulse after a rejected write
//   act_mode              : FC1 activation, captured with the token
//   tok                   : input/output token handshakes
//   busy                  : a token is in flight
// Pipeline: cycle k presents RAM addresses, cycle k+1 multiplies the
// registered weight with x/hid and accumulates. The extra drain cycle at the
// end of FC2 lets the last sum land before out_valid rises.
module mlp_stream
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int E          = 8,
    parameter int H          = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(H) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_we,
    input  logic [1:0]                w_sel,
    input  logic [$clog2(E*H)-1:0]    w_addr,
    input  logic [DATA_WIDTH-1:0]     w_data,
    output logic                      w_err,
    input  logic [1:0]                act_mode,
    mlp_stream_if.slave               tok,
    output logic                      busy
);
    localparam int AW   = $clog2(E*H);
    localparam int HW   = (H > 1) ? $clog2(H) : 1;
    localparam int EW   = (E > 1) ? $clog2(E) : 1;
    localparam int NMAX = (E > H) ? E : H;
    localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

    state_t state, state_nx;
    act_mode_t mode_reg, mac_mode;
    logic accept, w_in_range, w_ok;
    logic issue, last_issue, drain;
    logic [CW-1:0] o_cnt, i_cnt, last_o, last_i, o1, i1;
    logic v1, l2_1, first1, last1;
    logic [AW-1:0] w1_raddr, w2_raddr;

    logic signed [DATA_WIDTH-1:0] w1_mem [E*H];
    logic signed [DATA_WIDTH-1:0] w2_mem [E*H];
    logic signed [DATA_WIDTH-1:0] b1_mem [H];
    logic signed [DATA_WIDTH-1:0] b2_mem [E];
    logic signed [DATA_WIDTH-1:0] w1_q, w2_q, b1_q, b2_q;
    logic signed [DATA_WIDTH-1:0] x_reg [E];
    logic signed [DATA_WIDTH-1:0] hid   [H];
    logic signed [DATA_WIDTH-1:0] y_reg [E];
    logic signed [DATA_WIDTH-1:0] mac_a, mac_b, mac_bias, mac_result;

    assign tok.in_ready  = (state == S_IDLE);
    assign tok.out_valid = (state == S_OUT);
    assign busy          = (state != S_IDLE);
    assign accept        = tok.in_valid && tok.in_ready;

    always_comb begin
        w_in_range = 1'b0;
        case (w_sel_t'(w_sel))
            SEL_B1:  w_in_range = int'(w_addr) < H;
            SEL_B2:  w_in_range = int'(w_addr) < E;
            default: w_in_range = int'(w_addr) < E*H;
        endcase
        w_ok = w_we && (state == S_IDLE) && w_in_range;
    end

    // FC1 walks (outer h, inner e); FC2 walks (outer e, inner h).
    always_comb begin
        issue      = (state == S_FC1) || ((state == S_FC2) && !drain);
        last_o     = (state == S_FC2) ? CW'(E - 1) : CW'(H - 1);
        last_i     = (state == S_FC2) ? CW'(H - 1) : CW'(E - 1);
        last_issue = issue && (o_cnt == last_o) && (i_cnt == last_i);
        w1_raddr   = AW'(int'(i_cnt) * H + int'(o_cnt));
        w2_raddr   = AW'(int'(i_cnt) * E + int'(o_cnt));
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_FC1;
            S_FC1:  if (last_issue) state_nx = S_FC2;
            S_FC2:  if (v1 && l2_1 && last1 && (o1 == CW'(E - 1))) state_nx = S_OUT;
            S_OUT:  if (tok.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0; i_cnt <= '0; drain <= 1'b0;
            v1 <= 1'b0; l2_1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0;
            o1 <= '0; i1 <= '0;
            mode_reg <= ACT_NONE;
            w_err <= 1'b0;
        end else begin
            w_err  <= w_we && !w_ok;
            v1     <= issue;
            l2_1   <= (state == S_FC2);
            first1 <= (i_cnt == '0);
            last1  <= (i_cnt == last_i);
            o1     <= o_cnt;
            i1     <= i_cnt;
            if (accept) mode_reg <= act_mode_t'(act_mode);
            if (issue) begin
                if (i_cnt == last_i) begin
                    i_cnt <= '0;
                    o_cnt <= (o_cnt == last_o) ? '0 : o_cnt + 1'b1;
                end else begin
                    i_cnt <= i_cnt + 1'b1;
                end
            end
            if ((state == S_FC2) && last_issue) drain <= 1'b1;
            else if (state_nx != S_FC2)         drain <= 1'b0;
        end
    end

    // NOTE: RAMs and data arrays have no reset; their contents deliberately survive rst_n.
    always_ff @(posedge clk) begin
        if (w_ok && (w_sel_t'(w_sel) == SEL_W1)) w1_mem[w_addr] <= w_data;
        if (w_ok && (w_sel_t'(w_sel) == SEL_B1)) b1_mem[w_addr[HW-1:0]] <= w_data;
        if (w_ok && (w_sel_t'(w_sel) == SEL_W2)) w2_mem[w_addr] <= w_data;
        if (w_ok && (w_sel_t'(w_sel) == SEL_B2)) b2_mem[w_addr[EW-1:0]] <= w_data;
        w1_q <= w1_mem[w1_raddr];
        w2_q <= w2_mem[w2_raddr];
        b1_q <= b1_mem[o_cnt[HW-1:0]];
        b2_q <= b2_mem[o_cnt[EW-1:0]];
        if (accept)
            for (int e = 0; e < E; e++) x_reg[e] <= tok.in_data[e*DATA_WIDTH +: DATA_WIDTH];
        if (v1 && last1 && !l2_1) hid[o1[HW-1:0]] <= mac_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int e = 0; e < E; e++) y_reg[e] <= '0;
        else if (v1 && last1 && l2_1)
            y_reg[o1[EW-1:0]] <= mac_result;
    end

    always_comb begin
        tok.out_data = '0;
        for (int e = 0; e < E; e++) tok.out_data[e*DATA_WIDTH +: DATA_WIDTH] = y_reg[e];
    end

    always_comb begin
        mac_a    = l2_1 ? hid[i1[HW-1:0]] : x_reg[i1[EW-1:0]];
        mac_b    = l2_1 ? w2_q : w1_q;
        mac_bias = l2_1 ? b2_q : b1_q;
        mac_mode = l2_1 ? ACT_NONE : mode_reg;
    end

    mlp_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (v1),
        .first  (first1),
        .mode   (mac_mode),
        .bias   (mac_bias),
        .a      (mac_a),
        .b      (mac_b),
        .result (mac_result)
    );
endmodule
